// File: rtl/peak_bin_detect_if.sv
// peak_bin_detect_if
//   Groups the FFT-RAM read port, the frame strobe and the peak result of
//   peak_bin_detect.
//   slave  : the detector side (takes fftdone/ramq1, drives the rest).
//   master : the FFT / beamformer side.
//   fftdone    - one-cycle pulse, a new frame is in the FFT RAM
//   ramq1      - channel-1 RAM read data {re[27:14], im[13:0]} signed
//   rdaddr1    - channel-1 RAM read address
//   maxbin     - strongest bin of the last accepted scan
//   maxpwr     - re^2 + im^2 of maxbin
//   detectdone - one-cycle pulse when maxbin/maxpwr update
//   busy       - scan in progress
interface peak_bin_detect_if;
  logic        fftdone;
  logic [27:0] ramq1;
  logic [9:0]  rdaddr1;
  logic [9:0]  maxbin;
  logic [27:0] maxpwr;
  logic        detectdone;
  logic        busy;

  modport slave  (input  fftdone, ramq1,
                  output rdaddr1, maxbin, maxpwr, detectdone, busy);
  modport master (output fftdone, ramq1,
                  input  rdaddr1, maxbin, maxpwr, detectdone, busy);
endinterface

// File: rtl/peak_bin_detect.sv
// peak_bin_detect
//   After every fftdone, walks channel-1 FFT RAM over bins LO_BIN..HI_BIN at
//   one bin per cycle, forms |X|^2 = re^2 + im^2 and keeps the strongest bin
//   (strict compare, lowest bin wins ties). Commits maxbin/maxpwr with a
//   one-cycle detectdone pulse; between scans rdaddr1 is parked on maxbin so
//   the peak bin sample stays on ramq1 for the beamformer.
// Ports
//   clk  - system clock
//   KEY  - KEY[0] async active-low reset, KEY[3:1] unused
//   bus  - peak_bin_detect_if.slave (fftdone, ramq1, rdaddr1, maxbin,
//          maxpwr, detectdone, busy)
// Optional build macro
//   PEAK_THRESH_EN - a scan whose best power is below MIN_PWR is discarded:
//                    no detectdone, previous maxbin/maxpwr kept.
module peak_bin_detect #(
  parameter int          LO_BIN  = 1,
  parameter int          HI_BIN  = 511,
  parameter int          RD_LAT  = 2,
  parameter logic [27:0] MIN_PWR = 28'd4096
) (
  input  logic            clk,
  input  logic [3:0]      KEY,
  peak_bin_detect_if.slave bus
);
  localparam logic [9:0] LO = 10'(LO_BIN);
  localparam logic [9:0] HI = 10'(HI_BIN);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMPLETE} state_t;

  logic rst_n;
  assign rst_n = KEY[0];

  state_t                  state_q;
  logic [9:0]              rdaddr_q, maxbin_q, candbin_q, ptag_q;
  logic [27:0]             maxpwr_q, candpwr_q, pwr_q;
  logic                    detect_q, busy_q;
  // [RD_LAT-1:0] track addresses in flight through the RAM,
  // [RD_LAT] marks a valid sample in the power register.
  logic [RD_LAT:0]         vld_pipe;
  logic [RD_LAT-1:0][9:0]  tag_q;

  // Exact power: operands sign-extended so the products are full width;
  // both squares are non-negative and the sum tops out at 2^27.
  logic signed [27:0] re_x, im_x, re_sq, im_sq;
  logic        [27:0] pwr_d;
  assign re_x  = {{14{bus.ramq1[27]}}, bus.ramq1[27:14]};
  assign im_x  = {{14{bus.ramq1[13]}}, bus.ramq1[13:0]};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign pwr_d = 28'(re_sq + im_sq);

  logic commit_ok;
`ifdef PEAK_THRESH_EN
  logic committed_q;  // a scan has committed since reset
  assign commit_ok = (candpwr_q >= MIN_PWR);
`else
  logic unused_min_pwr;
  assign unused_min_pwr = ^MIN_PWR;
  assign commit_ok = 1'b1;
`endif

  logic unused_key;
  assign unused_key = ^KEY[3:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdaddr_q  <= '0;
      maxbin_q  <= '0;
      maxpwr_q  <= '0;
      candbin_q <= '0;
      candpwr_q <= '0;
      pwr_q     <= '0;
      ptag_q    <= '0;
      detect_q  <= 1'b0;
      busy_q    <= 1'b0;
      vld_pipe  <= '0;
      tag_q     <= '0;
`ifdef PEAK_THRESH_EN
      committed_q <= 1'b0;
`endif
    end else begin
      detect_q <= 1'b0;

      // address tags ride alongside the RAM read latency
      vld_pipe[0] <= (state_q == SCAN);
      tag_q[0]    <= rdaddr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_q[i]    <= tag_q[i-1];
      end
      vld_pipe[RD_LAT] <= vld_pipe[RD_LAT-1];
      pwr_q            <= pwr_d;
      ptag_q           <= tag_q[RD_LAT-1];

      if (vld_pipe[RD_LAT] && (pwr_q > candpwr_q)) begin
        candpwr_q <= pwr_q;
        candbin_q <= ptag_q;
      end

      case (state_q)
        IDLE, COMPLETE: begin
          if (bus.fftdone) begin
            state_q   <= SCAN;
            rdaddr_q  <= LO;
            candpwr_q <= '0;
            candbin_q <= LO;
            busy_q    <= 1'b1;
          end
        end
        SCAN: begin
          if (rdaddr_q == HI) state_q <= DRAIN;
          else                rdaddr_q <= rdaddr_q + 10'd1;
        end
        DRAIN: begin
          // empty pipe means the last sample was compared on the previous edge
          if (vld_pipe == '0) begin
            busy_q <= 1'b0;
            if (commit_ok) begin
              maxbin_q <= candbin_q;
              maxpwr_q <= candpwr_q;
              rdaddr_q <= candbin_q;
              detect_q <= 1'b1;
              state_q  <= COMPLETE;
`ifdef PEAK_THRESH_EN
              committed_q <= 1'b1;
`endif
            end else begin
              rdaddr_q <= maxbin_q;
`ifdef PEAK_THRESH_EN
              state_q  <= committed_q ? COMPLETE : IDLE;
`else
              state_q  <= COMPLETE;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdaddr1    = rdaddr_q;
  assign bus.maxbin     = maxbin_q;
  assign bus.maxpwr     = maxpwr_q;
  assign bus.detectdone = detect_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_peak_bin_detect.sv
// Self-checking bench for peak_bin_detect. Three instances (RD_LAT = 1, 2, 4)
// read one shared RAM image through per-instance latency models; expected
// results come from a direct scan of the RAM image.
module tb_peak_bin_detect;
  localparam int          LO   = 1;
  localparam int          HI   = 511;
  localparam int          N    = HI - LO + 1;
  localparam int          NI   = 3;
  localparam logic [27:0] MINP = 28'd4096;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    KEY;
  logic [NI-1:0] fftdone;
  logic [27:0]   mem [1024];

  logic [9:0]    rdaddr_w [NI];
  logic [9:0]    maxbin_w [NI];
  logic [27:0]   maxpwr_w [NI];
  logic          dd_w     [NI];
  logic          busy_w   [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_bin [NI];
  int exp_pwr [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : inst
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      peak_bin_detect_if bif();
      logic [27:0] q_pipe [LAT];

      peak_bin_detect #(.LO_BIN(LO), .HI_BIN(HI), .RD_LAT(LAT), .MIN_PWR(MINP))
        dut (.clk(clk), .KEY(KEY), .bus(bif));

      // RAM model: data for an address appears LAT edges after it is driven
      always @(posedge clk) begin
        q_pipe[0] <= mem[bif.rdaddr1];
        for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
      end

      assign bif.fftdone = fftdone[g];
      assign bif.ramq1   = q_pipe[LAT-1];
      assign rdaddr_w[g] = bif.rdaddr1;
      assign maxbin_w[g] = bif.maxbin;
      assign maxpwr_w[g] = bif.maxpwr;
      assign dd_w[g]     = bif.detectdone;
      assign busy_w[g]   = bif.busy;
    end
  endgenerate

  task automatic chk(input string tag, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got %0d exp %0d", tag, got, expv);
    end
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  function automatic logic [27:0] mk(input int re, input int im);
    logic [31:0] r, i;
    r = re; i = im;
    return {r[13:0], i[13:0]};
  endfunction

  function automatic int pwr_of(input logic [27:0] w);
    int re, im;
    re = $signed(w[27:14]);
    im = $signed(w[13:0]);
    return re * re + im * im;
  endfunction

  // strongest bin in range, first occurrence wins
  function automatic void model(output int b, output int p);
    b = LO; p = 0;
    for (int i = LO; i <= HI; i++)
      if (pwr_of(mem[i]) > p) begin p = pwr_of(mem[i]); b = i; end
  endfunction

  function automatic bit commits(input int p);
`ifdef PEAK_THRESH_EN
    return p >= int'(MINP);
`else
    return (p >= 0);
`endif
  endfunction

  function automatic void clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endfunction

  function automatic void rand_mem(input int r);
    for (int i = 0; i < 1024; i++)
      mem[i] = mk(int'($urandom_range(2 * r)) - r, int'($urandom_range(2 * r)) - r);
  endfunction

  // One frame on all instances; optional second fftdone at E0+dup_at.
  task automatic run_frame(input string tag, input int dup_at);
    int b, p;
    int first [NI];
    int cnt   [NI];
    bit ok;
    model(b, p);
    ok = commits(p);
    for (int g = 0; g < NI; g++) begin first[g] = -1; cnt[g] = 0; end
    @(negedge clk); fftdone = '1;
    @(negedge clk); fftdone = '0;            // E0 has passed
    for (int c = 1; c <= N + 12; c++) begin
      if (c == dup_at) fftdone = '1;
      @(negedge clk);
      fftdone = '0;
      for (int g = 0; g < NI; g++) begin
        if (dd_w[g]) begin cnt[g]++; if (first[g] < 0) first[g] = c; end
        if (c == 1) begin
          chk($sformatf("%s.busy%0d", tag, g), int'(busy_w[g]), 1);
          chk($sformatf("%s.hold%0d", tag, g), int'(maxbin_w[g]), exp_bin[g]);
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s.pulses%0d", tag, g), cnt[g], ok ? 1 : 0);
      if (ok) begin
        chk($sformatf("%s.lat%0d", tag, g), first[g], N + lat_of(g) + 2);
        exp_bin[g] = b; exp_pwr[g] = p;
      end
      chk($sformatf("%s.maxbin%0d", tag, g), int'(maxbin_w[g]), exp_bin[g]);
      chk($sformatf("%s.maxpwr%0d", tag, g), int'(maxpwr_w[g]), exp_pwr[g]);
      chk($sformatf("%s.rdaddr%0d", tag, g), int'(rdaddr_w[g]), exp_bin[g]);
      chk($sformatf("%s.idle%0d", tag, g), int'(busy_w[g]), 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s.rdaddr%0d", tag, g), int'(rdaddr_w[g]), 0);
      chk($sformatf("%s.maxbin%0d", tag, g), int'(maxbin_w[g]), 0);
      chk($sformatf("%s.maxpwr%0d", tag, g), int'(maxpwr_w[g]), 0);
      chk($sformatf("%s.dd%0d", tag, g), int'(dd_w[g]), 0);
      chk($sformatf("%s.busy%0d", tag, g), int'(busy_w[g]), 0);
    end
  endtask

  initial begin
    int cnt;
    KEY = 4'b0000;
    fftdone = '0;
    clear_mem();
    for (int g = 0; g < NI; g++) begin exp_bin[g] = 0; exp_pwr[g] = 0; end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    KEY = 4'b0001;

    // single peak
    clear_mem();
    mem[37] = mk(100, -50);
    run_frame("peak", 0);

    // ties at both range ends; out-of-range bins equal to the peak
    clear_mem();
    mem[1]   = mk(-8192, -8192);
    mem[511] = mk(-8192, -8192);
    mem[0]   = mk(-8192, -8192);
    mem[512] = mk(-8192, -8192);
    run_frame("tie", 0);

    // all-zero frame
    clear_mem();
    run_frame("zero", 0);

    // randomized frames: full scale, and tiny range for frequent ties
    for (int k = 0; k < 4; k++) begin
      rand_mem((k % 2 == 0) ? 8192 : 3);
      if (k % 2 == 1) mem[$urandom_range(HI, LO)] = mk(60, -70);
      run_frame($sformatf("rnd%0d", k), (k == 2) ? 100 : 0);
    end

    // reset mid-scan
    clear_mem();
    mem[300] = mk(500, 500);
    @(negedge clk); fftdone = '1;
    @(negedge clk); fftdone = '0;
    repeat (50) @(negedge clk);
    KEY[0] = 1'b0;
    #1;
    chk_zero("midrst");
    for (int g = 0; g < NI; g++) begin exp_bin[g] = 0; exp_pwr[g] = 0; end
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) if (dd_w[g]) cnt++;
    end
    KEY[0] = 1'b1;
    repeat (N + 12) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) if (dd_w[g]) cnt++;
    end
    chk("midrst.nopulse", cnt, 0);
    run_frame("postrst", 0);

    // back-to-back, one instance at a time so each sees fftdone right after
    // its own commit
    for (int g = 0; g < NI; g++) begin
      logic [NI-1:0] m;
      int pulses;
      bit b_started;
      m = NI'(1) << g;
      pulses = 0;
      b_started = 1'b0;
      clear_mem();
      mem[200] = mk(300, 0);
      @(negedge clk); fftdone = m;
      @(negedge clk); fftdone = '0;
      for (int c = 1; c <= 1100; c++) begin
        @(negedge clk);
        fftdone = '0;
        if (dd_w[g]) begin
          pulses++;
          if (!b_started) begin
            chk($sformatf("b2b.lat%0d", g), c, N + lat_of(g) + 2);
            chk($sformatf("b2b.binA%0d", g), int'(maxbin_w[g]), 200);
            clear_mem();
            mem[5] = mk(50, 50);
            fftdone = m;
            b_started = 1'b1;
          end
        end
        if (c == 99) fftdone = m;
      end
      exp_bin[g] = 5;
      exp_pwr[g] = 5000;
      chk($sformatf("b2b.pulses%0d", g), pulses, 2);
      chk($sformatf("b2b.binB%0d", g), int'(maxbin_w[g]), 5);
      chk($sformatf("b2b.pwrB%0d", g), int'(maxpwr_w[g]), 5000);
      chk($sformatf("b2b.rdaddr%0d", g), int'(rdaddr_w[g]), 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
